// File: rtl/prdct_tile_addr_gen.sv
// Product-tile ROM address generator with sideband aligned to ImageROM q.
// Also owns the frame-synchronous "selected product" highlight border.
module prdct_tile_addr_gen #(
    parameter int PRDCT_PIC_WIDTH    = 100,
    parameter int PRDCT_PIC_HEIGHT   = 100,
    parameter int NUM_OF_PRDCT       = 12,
    parameter int TILE_X0            = 100,
    parameter int TILE_Y0            = 75,
    parameter int PITCH_X            = 150,
    parameter int PITCH_Y            = 175,
    parameter int BORDER             = 4,
    parameter int VISIBLE_V          = 600,
    parameter int ROM_LATENCY        = 2,
    parameter int CNTR_WIDTH_H       = 10,
    parameter int CNTR_WIDTH_V       = 10,
    parameter int ROM_ADDR_BUS_WIDTH = 17
) (
    input  logic                          VGA_CLK,
    input  logic                          RST_N,
    input  logic [CNTR_WIDTH_H-1:0]       CounterX,
    input  logic [CNTR_WIDTH_V-1:0]       CounterY,
    input  logic                          inDisplayArea,
    input  logic                          HS_IN,
    input  logic                          VS_IN,
    input  logic [3:0]                    SEL_PRDCT,
    input  logic                          SEL_VALID,
    output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_ADDR,
    output logic                          PIX_VALID,
    output logic                          IN_TILE,
    output logic                          HILITE,
    output logic [3:0]                    TILE_IDX,
    output logic                          HS_OUT,
    output logic                          VS_OUT
);

    localparam int RXW      = $clog2(PRDCT_PIC_WIDTH);
    localparam int RYW      = $clog2(PRDCT_PIC_HEIGHT);
    localparam int TILE_PIX = PRDCT_PIC_WIDTH * PRDCT_PIC_HEIGHT;

    typedef logic [CNTR_WIDTH_H-1:0]       xc_t;
    typedef logic [CNTR_WIDTH_V-1:0]       yc_t;
    typedef logic [ROM_ADDR_BUS_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic       valid;
        logic       in_tile;
        logic       hilite;
        logic [3:0] idx;
        logic       hs;
        logic       vs;
    } side_t;

    localparam side_t SIDE_RST = '{
        valid: 1'b0, in_tile: 1'b0, hilite: 1'b0,
        idx: 4'd0, hs: 1'b1, vs: 1'b1
    };

    function automatic xc_t col_x(input logic [1:0] c);
        unique case (c)
            2'd0: col_x = xc_t'(TILE_X0);
            2'd1: col_x = xc_t'(TILE_X0 + PITCH_X);
            2'd2: col_x = xc_t'(TILE_X0 + 2 * PITCH_X);
            2'd3: col_x = xc_t'(TILE_X0 + 3 * PITCH_X);
        endcase
    endfunction

    function automatic yc_t row_y(input logic [1:0] r);
        case (r)
            2'd0:    row_y = yc_t'(TILE_Y0);
            2'd1:    row_y = yc_t'(TILE_Y0 + PITCH_Y);
            2'd2:    row_y = yc_t'(TILE_Y0 + 2 * PITCH_Y);
            default: row_y = '0;
        endcase
    endfunction

    function automatic addr_t row_base(input logic [1:0] r);
        case (r)
            2'd1:    row_base = addr_t'(4 * TILE_PIX);
            2'd2:    row_base = addr_t'(8 * TILE_PIX);
            default: row_base = '0;
        endcase
    endfunction

    function automatic addr_t col_base(input logic [1:0] c);
        unique case (c)
            2'd0: col_base = '0;
            2'd1: col_base = addr_t'(TILE_PIX);
            2'd2: col_base = addr_t'(2 * TILE_PIX);
            2'd3: col_base = addr_t'(3 * TILE_PIX);
        endcase
    endfunction

    // Line offset as a sum of shifted copies: one adder per set bit of the width.
    function automatic addr_t mul_w(input logic [RYW-1:0] v);
        mul_w = '0;
        for (int b = 0; b < 32; b++) begin
            if (PRDCT_PIC_WIDTH[b]) mul_w = mul_w + (addr_t'(v) << b);
        end
    endfunction

    logic           col_hit, row_hit, tile_hit;
    logic [1:0]     col, row;
    logic [RXW-1:0] rx;
    logic [RYW-1:0] ry;
    addr_t          addr_nxt;

    always_comb begin
        col_hit = 1'b0;
        col     = '0;
        rx      = '0;
        for (int c = 0; c < 4; c++) begin
            if (CounterX >= col_x(2'(c)) &&
                CounterX <  col_x(2'(c)) + xc_t'(PRDCT_PIC_WIDTH)) begin
                col_hit = 1'b1;
                col     = 2'(c);
                rx      = RXW'(CounterX - col_x(2'(c)));
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row     = '0;
        ry      = '0;
        for (int r = 0; r < 3; r++) begin
            if (CounterY >= row_y(2'(r)) &&
                CounterY <  row_y(2'(r)) + yc_t'(PRDCT_PIC_HEIGHT)) begin
                row_hit = 1'b1;
                row     = 2'(r);
                ry      = RYW'(CounterY - row_y(2'(r)));
            end
        end
    end

    assign tile_hit = col_hit & row_hit;
    assign addr_nxt = row_base(row) + col_base(col) + mul_w(ry) + addr_t'(rx);

    logic [3:0] sel_pending, sel_active;
    logic       sel_on, frame_edge;
    xc_t        hx;
    yc_t        hy;
    logic       x_out, y_out, x_in, y_in, hilite_nxt;

    assign sel_on = sel_active < 4'(NUM_OF_PRDCT);
    assign hx     = col_x(sel_active[1:0]);
    assign hy     = row_y(sel_active[3:2]);

    assign x_out = CounterX >= hx - xc_t'(BORDER) &&
                   CounterX <  hx + xc_t'(PRDCT_PIC_WIDTH + BORDER);
    assign y_out = CounterY >= hy - yc_t'(BORDER) &&
                   CounterY <  hy + yc_t'(PRDCT_PIC_HEIGHT + BORDER);
    assign x_in  = CounterX >= hx && CounterX < hx + xc_t'(PRDCT_PIC_WIDTH);
    assign y_in  = CounterY >= hy && CounterY < hy + yc_t'(PRDCT_PIC_HEIGHT);

    assign hilite_nxt = sel_on & x_out & y_out & ~(x_in & y_in) & inDisplayArea;

    assign frame_edge = (CounterX == '0) && (CounterY == yc_t'(VISIBLE_V));

    addr_t addr_q;
    side_t s1;
    side_t sr [ROM_LATENCY];

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q      <= '0;
            s1          <= SIDE_RST;
            sel_pending <= 4'hF;
            sel_active  <= 4'hF;
        end else begin
            if (tile_hit) addr_q <= addr_nxt;
            s1.valid   <= inDisplayArea;
            s1.in_tile <= tile_hit & inDisplayArea;
            s1.hilite  <= hilite_nxt;
            s1.idx     <= (tile_hit & inDisplayArea) ? {row, col} : 4'd0;
            s1.hs      <= HS_IN;
            s1.vs      <= VS_IN;
            if (SEL_VALID) sel_pending <= SEL_PRDCT;
            // Old pending value is taken, so a coincident strobe waits a frame.
            if (frame_edge) sel_active <= sel_pending;
        end
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ROM_LATENCY; i++) sr[i] <= SIDE_RST;
        end else begin
            sr[0] <= s1;
            for (int i = 1; i < ROM_LATENCY; i++) sr[i] <= sr[i-1];
        end
    end

    assign ROM_ADDR  = addr_q;
    assign PIX_VALID = sr[ROM_LATENCY-1].valid;
    assign IN_TILE   = sr[ROM_LATENCY-1].in_tile;
    assign HILITE    = sr[ROM_LATENCY-1].hilite;
    assign TILE_IDX  = sr[ROM_LATENCY-1].idx;
    assign HS_OUT    = sr[ROM_LATENCY-1].hs;
    assign VS_OUT    = sr[ROM_LATENCY-1].vs;

endmodule

// File: doc/prdct_tile_addr_gen.md
# prdct_tile_addr_gen

Address generator and sideband aligner that sits between `HVSync_Generator` and `ImageROM`/the VGA colour output stage. It maps raster coordinates onto a 4×3 grid of 100×100 product tiles on the 800×600 screen, and computes the `ImageROM` address for the current pixel. It delays sync, blanking and tile flags so they line up with the ROM's registered read data. It also owns the "selected product" highlight border, which is updated only at frame boundaries so the border never tears.

## Interface
- `PRDCT_PIC_WIDTH`, 100, tile width in pixels
- `PRDCT_PIC_HEIGHT`, 100, tile height in pixels
- `NUM_OF_PRDCT`, 12, number of tiles (fixed 4 columns × 3 rows)
- `TILE_X0`, 100, X of left edge of column 0
- `TILE_Y0`, 75, Y of top edge of row 0
- `PITCH_X`, 150, X distance between column left edges
- `PITCH_Y`, 175, Y distance between row top edges
- `BORDER`, 4, highlight border thickness in pixels, outside the tile
- `VISIBLE_V`, 600, visible line count; the frame boundary is `CounterY == VISIBLE_V`
- `ROM_LATENCY`, 2, `ImageROM` address-to-q latency in cycles
- `CNTR_WIDTH_H` / `CNTR_WIDTH_V`, 10 / 10, coordinate widths
- `ROM_ADDR_BUS_WIDTH`, 17, ROM address width
- `VGA_CLK`  in  1  pixel clock; the only clock
- `RST_N`  in  1  reset, asynchronous, active-low
- `CounterX`  in  10  raster X from `HVSync_Generator`
- `CounterY`  in  10  raster Y from `HVSync_Generator`
- `inDisplayArea`  in  1  visible-pixel flag
- `HS_IN`, `VS_IN`  in  1 each  raw syncs from `HVSync_Generator`
- `SEL_PRDCT`  in  4  requested highlighted tile; values 12–15 mean none
- `SEL_VALID`  in  1  one-cycle strobe that captures `SEL_PRDCT`
- `ROM_ADDR`  out  17  `ImageROM` address
- `PIX_VALID`  out  1  `inDisplayArea`, aligned to ROM q
- `IN_TILE`  out  1  pixel lies inside a tile, aligned to ROM q
- `HILITE`  out  1  pixel lies in the selected tile's border, aligned to ROM q
- `TILE_IDX`  out  4  tile index of the pixel, aligned to ROM q
- `HS_OUT`, `VS_OUT`  out  1 each  syncs aligned to ROM q

## Operation
- **Tile decode.** Column c (0–3) spans X in [TILE_X0+c·PITCH_X, +PRDCT_PIC_WIDTH). Row r (0–2) spans Y in [TILE_Y0+r·PITCH_Y, +PRDCT_PIC_HEIGHT). Tile index k = 4r+c.
- Within a tile, rx = X − column start and ry = Y − row start.
- **Address.** `ROM_ADDR` = k·10000 + ry·100 + rx. The ROM holds tiles back to back, row-major; the maximum address is 119999.
  - Use compare/subtract against constant edges and shift-add constant multiplies. Do not infer a DSP multiplier.
  - Outside every tile, `ROM_ADDR` holds its last value and `IN_TILE` is 0.
- **Highlight.** `HILITE` is 1 for the selected tile's expanded rectangle minus its interior:
  - X in [start−BORDER, end+BORDER)
  - Y in [start−BORDER, end+BORDER)
  - the tile interior itself is excluded
  - `HILITE` is 0 when no tile is selected. `HILITE` and `IN_TILE` are never both 1.
- **Selection registers.**
  - `sel_pending` loads `SEL_PRDCT` on any cycle with `SEL_VALID`=1; the last strobe wins.
  - `sel_active` loads `sel_pending` on the cycle where `CounterX == 0` and `CounterY == VISIBLE_V`.
  - If `SEL_VALID` and the boundary coincide, the new value reaches `sel_active` at the next frame boundary, not this one.
  - A value ≥ 12 in `sel_active` means none.
- `TILE_IDX` is 0 when `IN_TILE` is 0.
- **Gating.** `IN_TILE` and `HILITE` are gated by `inDisplayArea`.

## Timing
- **Stage 1 (cycle t+1).** Registered: `ROM_ADDR`, and internal in_tile / hilite / tile_idx / valid / HS / VS.
- **Sideband delay.** Stage-1 sideband goes through a `ROM_LATENCY`-deep shift register.
- **Output alignment.** Outputs for coordinates presented at cycle t appear at t+1+`ROM_LATENCY` (t+3 by default). This matches ROM q for the address issued at t+1.
- **Throughput.** One pixel per clock; no stalls, no backpressure.
- **Reset values.**
  - `ROM_ADDR`=0, `PIX_VALID`=0, `IN_TILE`=0, `HILITE`=0, `TILE_IDX`=0
  - `HS_OUT`=1, `VS_OUT`=1 (inactive)
  - All shift-register stages take the same values.
  - `sel_pending` = `sel_active` = 15.
- **Reset mid-frame.** Outputs go to reset values immediately (asynchronous).
  - After `RST_N` rises, the first clocked coordinates produce correct outputs after the same t+3 latency.
  - Coordinates come directly from the inputs, so no frame resynchronisation is needed.
  - The selection stays none until a new strobe and a frame boundary.

## Test plan
- **Tile edges.** X=100,Y=75 -> three cycles later `ROM_ADDR`=0 (visible one cycle after input), `IN_TILE`=1, `TILE_IDX`=0. X=199,Y=174 -> `ROM_ADDR`=9999.
- **Tile bases.** X=250,Y=75 -> `ROM_ADDR`=10000, `TILE_IDX`=1. X=649,Y=524 -> `ROM_ADDR`=119999, `TILE_IDX`=11.
- **Gaps.** X=200,Y=75 after X=199 -> `IN_TILE`=0 and `ROM_ADDR` held at 99. X=99 -> `IN_TILE`=0.
- **Alignment.** `inDisplayArea` rises at cycle t with `HS_IN` toggling -> `PIX_VALID` rises and `HS_OUT` toggles exactly at t+3.
- **Highlight.**
  - `SEL_VALID` with `SEL_PRDCT`=5 at Y=300 -> `HILITE` unchanged for the rest of that frame.
  - Next frame: X=246,Y=250 -> `HILITE`=1; X=250,Y=250 -> `HILITE`=0 and `IN_TILE`=1; X=354,Y=300 -> `HILITE`=0.
  - `SEL_PRDCT`=13 -> no `HILITE` anywhere after the next boundary.
- **Reset mid-frame.** Assert `RST_N`=0 at X=300,Y=100 -> all outputs at reset values that cycle. Release, then X=301,Y=100 -> `ROM_ADDR`=10000+25·100+51=12551 one cycle later, with `IN_TILE`=1 three cycles later.
